led_pwm_fader: RTL and testbench



---
 rtl/led_pkg.sv | 11 +
 rtl/led_pwm_fader_if.sv | 10 +
 rtl/led_fade_channel.sv | 40 ++++
 rtl/led_pwm_fader.sv | 48 ++++
 tb/tb_led_pwm_fader.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// led_pkg: shared LED count, fade state type and level step helper for led_pwm_fader
package led_pkg;
  localparam int NUM_LEDS = 4;
  typedef enum logic [1:0] {FADE_OFF, FADE_RAMP_UP, FADE_ON, FADE_RAMP_DOWN} fade_state_e;
  function automatic logic [31:0] fade_next(input logic [31:0] level, input logic [31:0] max_level,
                                            input logic target, input logic tick);
    return !tick ? level :
           (target && level < max_level) ? level + 32'd1 :
           (!target && level != 32'd0) ? level - 32'd1 : level;
  endfunction
endpackage

// File: rtl/led_pwm_fader_if.sv
// led_pwm_fader_if: commanded pattern/enable towards the fader, LED drive and busy back
interface led_pwm_fader_if;
  import led_pkg::*;
  logic [NUM_LEDS-1:0] led_in;
  logic [NUM_LEDS-1:0] led_out;
  logic enable;
  logic busy;
  modport master(output led_in, enable, input led_out, busy);
  modport slave(input led_in, enable, output led_out, busy);
endinterface

// File: rtl/led_fade_channel.sv
// led_fade_channel: one LED's level ramp, fade FSM and registered PWM compare (GAMMA_EN squares the duty)
module led_fade_channel
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                target,
  input  logic                step_tick,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic [PWM_BITS-1:0] level,
  output logic                ramping,
  output logic                pwm
);
  localparam logic [PWM_BITS-1:0] MAX = '1;
  fade_state_e state;
  logic [PWM_BITS-1:0] goal;
  logic [PWM_BITS-1:0] duty;
  assign goal = {PWM_BITS{target}};
  always_comb state = level < goal ? FADE_RAMP_UP : level > goal ? FADE_RAMP_DOWN : target ? FADE_ON : FADE_OFF;
  assign ramping = state == FADE_RAMP_UP || state == FADE_RAMP_DOWN;
`ifdef GAMMA_EN
  logic [2*PWM_BITS-1:0] sq;
  assign sq = (2*PWM_BITS)'(level) * (2*PWM_BITS)'(level);
  assign duty = sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign duty = level;
`endif
  // full scale is forced solid so the pin never ripples when fully on
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      level <= '0;
      pwm   <= 1'b0;
    end else begin
      level <= PWM_BITS'(fade_next(32'(level), 32'(MAX), target, step_tick && enable));
      pwm   <= enable && level != '0 && (level == MAX || duty > pwm_cnt);
    end
endmodule

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: syncs the LED pattern, ramps each channel's brightness and renders it with a shared PWM counter
// GAMMA_EN: when defined, channels use a squared (gamma) duty instead of the linear level
module led_pwm_fader
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned STEP_DIV = 16384
) (
  input logic            clk,
  input logic            rst_n,
  led_pwm_fader_if.slave bus
);
  localparam int unsigned SW = $clog2(STEP_DIV);
  logic [NUM_LEDS-1:0] led_meta, led_sync, ramping, pwm;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] level [NUM_LEDS];
  logic [SW-1:0] step_cnt;
  logic step_tick;
  assign step_tick = step_cnt == SW'(STEP_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      led_meta <= '0;
      led_sync <= '0;
      pwm_cnt  <= '0;
      step_cnt <= '0;
      bus.busy <= 1'b0;
    end else begin
      led_meta <= bus.led_in;
      led_sync <= led_meta;
      pwm_cnt  <= pwm_cnt + 1'b1;
      if (bus.enable) step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
      bus.busy <= |ramping;
    end
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_fade_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .target   (led_sync[i]),
      .step_tick(step_tick),
      .enable   (bus.enable),
      .pwm_cnt  (pwm_cnt),
      .level    (level[i]),
      .ramping  (ramping[i]),
      .pwm      (pwm[i])
    );
  end
  assign bus.led_out = pwm;
endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: random and directed stimulus against a cycle-level behavioural model of the fader
module tb_led_pwm_fader;
  import led_pkg::*;
  localparam int PB = 4, SD = 2, MX = 15;
  logic clk = 1'b0, rst_n = 1'b0, rst2_n = 1'b0;
  int total = 0, bad = 0;
  int m_lvl [4];
  logic [3:0] m_out;
  logic m_busy;
  int n, en_n;
  logic [3:0] hist [$];
  always #5 clk = ~clk;
  led_pwm_fader_if bus();
  led_pwm_fader_if bus2();
  led_pwm_fader #(.PWM_BITS(PB), .STEP_DIV(SD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  led_pwm_fader #(.PWM_BITS(PB), .STEP_DIV(1000)) dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2.slave));

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int duty(input int l);
`ifdef GAMMA_EN
    return (l * l) >> PB;
`else
    return l;
`endif
  endfunction

  task automatic m_reset();
    foreach (m_lvl[i]) m_lvl[i] = 0;
    hist = {4'b0, 4'b0};
    n = 0;
    en_n = 0;
    m_out = '0;
    m_busy = 1'b0;
  endtask

  // one clock edge: target is the pattern from two edges ago, steps every SD enabled cycles
  task automatic m_edge(input logic [3:0] li, input logic en);
    int cnt, t;
    logic tick;
    cnt = n % (1 << PB);
    tick = en && (en_n % SD == SD - 1);
    m_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t = hist[0][i] ? MX : 0;
      if (m_lvl[i] != t) m_busy = 1'b1;
      m_out[i] = en && m_lvl[i] != 0 && (m_lvl[i] == MX || duty(m_lvl[i]) > cnt);
      if (tick) m_lvl[i] += (t > m_lvl[i]) ? 1 : (t < m_lvl[i]) ? -1 : 0;
    end
    void'(hist.pop_front());
    hist.push_back(li);
    n++;
    en_n += int'(en);
  endtask

  task automatic step();
    @(posedge clk);
    m_edge(bus.led_in, bus.enable);
    @(negedge clk);
    check("led_out", int'(bus.led_out), int'(m_out));
    check("busy", int'(bus.busy), int'(m_busy));
    for (int i = 0; i < 4; i++) check($sformatf("level%0d", i), int'(dut.level[i]), m_lvl[i]);
  endtask

  task automatic run(input int k);
    for (int j = 0; j < k; j++) step();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_out", int'(bus.led_out), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_lvl3", int'(dut.level[3]), 0);
    @(negedge clk);
    m_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    int dpeak, mpeak, h4, h12;
    bus.led_in = '0;
    bus.enable = 1'b1;
    bus2.led_in = 4'b0001;
    bus2.enable = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(20);
    bus.led_in = 4'b1000;
    run(3);
    check("busy_rise", int'(bus.busy), 1);
    run(40);
    check("on_level", int'(dut.level[3]), MX);
    check("on_out", int'(bus.led_out), 4'b1000);
    check("on_idle", int'(bus.busy), 0);
    bus.led_in = '0;
    async_reset();
    run(100);
    check("idle_out", int'(bus.led_out), 0);
    check("idle_busy", int'(bus.busy), 0);
    bus.led_in = 4'b1000;
    for (int k = 0; k < 200 && dut.level[3] != 4'd7; k++) step();
    check("reach7", int'(dut.level[3]), 7);
    bus.led_in = '0;
    dpeak = 0;
    mpeak = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (int'(dut.level[3]) > dpeak) dpeak = int'(dut.level[3]);
      if (m_lvl[3] > mpeak) mpeak = m_lvl[3];
    end
    check("down_peak", dpeak, mpeak);
    check("down_out", int'(bus.led_out), 0);
    check("down_busy", int'(bus.busy), 0);
    bus.led_in = 4'b1000;
    for (int k = 0; k < 200 && m_lvl[3] != 5; k++) step();
    bus.enable = 1'b0;
    run(20);
    check("frz_lvl", int'(dut.level[3]), 5);
    check("frz_busy", int'(bus.busy), 1);
    check("frz_out", int'(bus.led_out), 0);
    bus.enable = 1'b1;
    run(40);
    bus.led_in = 4'b1111;
    run(40);
    check("all_on", int'(bus.led_out), 4'b1111);
    bus.led_in = 4'b0000;
    run(40);
    check("all_off", int'(bus.led_out), 0);
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(19) == 0) bus.led_in = 4'($urandom);
      if ($urandom_range(29) == 0) bus.enable = ~bus.enable;
      step();
    end
    bus.enable = 1'b1;
    bus.led_in = '0;
    async_reset();
    h4 = 0;
    h12 = 0;
    rst2_n = 1'b1;
    for (int k = 1; k <= 12515; k++) begin
      @(negedge clk);
      if (k >= 4200 && k < 4216) h4 += int'(bus2.led_out[0]);
      if (k >= 12500 && k < 12516) h12 += int'(bus2.led_out[0]);
    end
    check("duty4", h4, duty(4));
    check("duty12", h12, duty(12));
    check("busy2", int'(bus2.busy), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
